midi_msg_parser: RTL and testbench
==================================

# midi_msg_parser

Channel-voice MIDI message parser between the serial MIDI receiver and the controller/voice logic. Consumes one received byte per `byte_valid` strobe and tracks status and running status. Emits fully assembled messages as registered data bytes plus one-cycle command pulses. Its `ictrl`, `ictrl_data` and `pitch_cmd` outputs feed the controller block that builds the 14-bit pitch-bend value.

## Interface
Parameters:
- `MIDI_CH`, 0: receive channel, 0–15.
- `OMNI`, 1: 1 accepts all channels; 0 accepts only `MIDI_CH`.
- `SENSE_TIMEOUT`, 7_500_000: active-sensing timeout in CLOCK_25 cycles (300 ms).

Ports:
- `CLOCK_25`, in, 1: system clock.
- `reset_reg_N`, in, 1: asynchronous, active-low reset.
- `byte_in`, in, 8: received MIDI byte.
- `byte_valid`, in, 1: one-cycle strobe; `byte_in` is valid in that cycle.
- `rx_err`, in, 1: framing error strobe from the receiver.
- `ictrl`, out, 8: first data byte (note, controller number, program, pitch LSB).
- `ictrl_data`, out, 8: second data byte (velocity, controller value, pitch MSB); 0 for one-data-byte messages.
- `cmd_ch`, out, 4: channel of the last emitted message.
- `note_on`, out, 1: pulse.
- `note_off`, out, 1: pulse.
- `ctrl_cmd`, out, 1: pulse.
- `prog_cmd`, out, 1: pulse.
- `pitch_cmd`, out, 1: pulse.
- `all_off`, out, 1: pulse on active-sensing loss.

## Operation
- Reset values:
  - `ictrl`=0, `ictrl_data`=0, `cmd_ch`=0.
  - All pulses 0.
  - State S_NOSTAT; running status cleared; sensing disarmed.
- States:
  - S_NOSTAT: no valid status.
  - S_D1: awaiting data byte 1.
  - S_D2: awaiting data byte 2.
- Byte classes, evaluated only when `byte_valid`=1:
  - 0x80–0xEF (channel status): latch status, go to S_D1. Discards any partial message.
  - 0xF0–0xF7 (system common, SysEx): clear running status, go to S_NOSTAT. SysEx data is ignored until the next status byte.
  - 0xF8–0xFF (realtime): no state change, never breaks a partial message. 0xFE arms sensing.
  - Data byte (bit7=0):
    - In S_NOSTAT: discarded.
    - In S_D1: store as d1. For 0xC_/0xD_, complete the message and stay in S_D1. Otherwise go to S_D2.
    - In S_D2: store as d2, complete the message, return to S_D1 (running status).
- Completion:
  - If channel filter passes (OMNI=1, or channel == MIDI_CH): register `ictrl`=d1, `ictrl_data`=d2 (or 0), `cmd_ch`=channel, and pulse exactly one command.
  - If filter fails: outputs unchanged, no pulse.
- Command mapping:
  - 0x9_ with d2≠0 → `note_on`.
  - 0x9_ with d2=0 → `note_off`.
  - 0x8_ → `note_off`.
  - 0xB_ → `ctrl_cmd`.
  - 0xC_ → `prog_cmd`.
  - 0xE_ → `pitch_cmd`.
  - 0xA_ and 0xD_ are parsed and consumed, with no pulse and no output update.
- `ictrl`/`ictrl_data` hold until the next passing completion. Downstream captures on both edges of its delayed `pitch_cmd`, so stability for ≥2 cycles after the pulse is mandatory.
- `rx_err` forces S_NOSTAT and clears running status. If it coincides with `byte_valid`, the byte is dropped.

## Timing
- Completion byte strobe in cycle N → outputs updated and pulse high in cycle N+1, for exactly one cycle.
- Back-to-back `byte_valid` on consecutive cycles is supported with no loss.
- Reset is asynchronous at any point, including mid-message. The partial message is lost and no pulse is emitted.

## Configuration
- Macro: `MIDI_ACTIVE_SENSE_EN`.
- Defined:
  - After 0xFE is received, a down-counter reloads to SENSE_TIMEOUT on every `byte_valid`.
  - On reaching 0: one-cycle `all_off`, then disarm.
  - Reset and `rx_err` also disarm.
- Undefined:
  - No counter; `all_off` tied 0.
  - 0xFE is treated as ordinary realtime.

## Structure
- Shared package `midi_pkg`:
  - Status-nibble constants (NOTE_OFF=4'h8 … PITCH=4'hE).
  - Parser state encoding.
  - Default SENSE_TIMEOUT.
- Sub-module `midi_sense_timer`: arm/reload/expire counter, instantiated only under the macro.

## Test plan
- 0x90,0x3C,0x64 → cycle after last byte: `note_on`=1, `ictrl`=0x3C, `ictrl_data`=0x64, `cmd_ch`=0.
- 0xE0,0x00,0x40 then running-status 0x7F,0x7F → two `pitch_cmd` pulses: first `ictrl`=0x00/`ictrl_data`=0x40; second 0x7F/0x7F, both held ≥2 cycles.
- 0x91,0x40,0xF8,0x00 with OMNI=1 → `note_off` (velocity 0), `cmd_ch`=1; realtime byte ignored.
- OMNI=0, MIDI_CH=2: 0xB3,0x07,0x50 → no pulse, outputs unchanged. 0xB2,0x07,0x50 → `ctrl_cmd`, `ictrl`=0x07.
- 0xC0,0x05,0x06 → two `prog_cmd` pulses, `ictrl`=0x05 then 0x06, `ictrl_data`=0. Reset asserted after 0x90,0x3C → no pulse, and the following 0x40 is discarded.
- MIDI_ACTIVE_SENSE_EN, SENSE_TIMEOUT=100: 0xFE then idle → `all_off` exactly 100 cycles after the last strobe. A byte at cycle 90 restarts the count.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI channel-voice parser: status nibbles,
// parser state encoding and the default active-sensing timeout.
package midi_pkg;

    // Upper nibble of channel-voice status bytes
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CTRL_CHG = 4'hB;
    localparam logic [3:0] PROG_CHG = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    // 300 ms at 25 MHz
    localparam int unsigned DEFAULT_SENSE_TIMEOUT = 7_500_000;

    typedef enum logic [1:0] {
        StNoStat,
        StD1,
        StD2
    } parse_state_e;

    // Program change and channel aftertouch carry a single data byte
    function automatic logic is_one_data_byte(input logic [3:0] nibble);
        return (nibble == PROG_CHG) || (nibble == CHAN_AT);
    endfunction

endpackage

// File: rtl/midi_sense_timer.sv
// Active-sensing watchdog: armed by 0xFE, reloaded by every received byte,
// emits a one-cycle expire pulse after TIMEOUT idle cycles, then disarms.
module midi_sense_timer import midi_pkg::*; #(
    parameter int unsigned TIMEOUT = DEFAULT_SENSE_TIMEOUT
) (
    input  logic CLOCK_25,
    input  logic reset_reg_N,
    input  logic arm,
    input  logic reload,
    input  logic disarm,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Loads TIMEOUT-1 so the registered pulse lands TIMEOUT cycles after the last strobe
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

    logic            armed_q, armed_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            expire_q, expire_d;

    // Next-state: disarm wins, any byte reloads, otherwise count down while armed
    always_comb begin
        armed_d  = armed_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (disarm) begin
            armed_d = 1'b0;
        end else if (reload) begin
            cnt_d = LoadVal;
            if (arm) begin
                armed_d = 1'b1;
            end
        end else if (armed_q) begin
            if (cnt_q <= CntW'(1)) begin
                expire_d = 1'b1;
                armed_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/midi_msg_parser.sv
// Channel-voice MIDI message parser with running status. Realtime bytes pass
// through without disturbing a partial message. Define MIDI_ACTIVE_SENSE_EN to
// enable the active-sensing watchdog driving all_off.
module midi_msg_parser import midi_pkg::*; #(
    parameter int unsigned MIDI_CH       = 0,
    parameter bit          OMNI          = 1'b1,
    parameter int unsigned SENSE_TIMEOUT = DEFAULT_SENSE_TIMEOUT
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       rx_err,
    output logic [7:0] ictrl,
    output logic [7:0] ictrl_data,
    output logic [3:0] cmd_ch,
    output logic       note_on,
    output logic       note_off,
    output logic       ctrl_cmd,
    output logic       prog_cmd,
    output logic       pitch_cmd,
    output logic       all_off
);

    localparam logic [3:0] RxCh = 4'(MIDI_CH);

    parse_state_e state_q, state_d;
    logic [7:0]   status_q, status_d;
    logic [7:0]   d1_q, d1_d;
    logic [7:0]   ictrl_q, ictrl_d;
    logic [7:0]   ictrl_data_q, ictrl_data_d;
    logic [3:0]   cmd_ch_q, cmd_ch_d;
    logic         note_on_q, note_on_d;
    logic         note_off_q, note_off_d;
    logic         ctrl_q, ctrl_d;
    logic         prog_q, prog_d;
    logic         pitch_q, pitch_d;

    logic         complete;
    logic         emit;
    logic         ch_pass;
    logic [7:0]   cmp_d1, cmp_d2;

    assign ch_pass = OMNI || (status_q[3:0] == RxCh);

    // Byte classification, message assembly and command decode
    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        d1_d         = d1_q;
        ictrl_d      = ictrl_q;
        ictrl_data_d = ictrl_data_q;
        cmd_ch_d     = cmd_ch_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;
        ctrl_d       = 1'b0;
        prog_d       = 1'b0;
        pitch_d      = 1'b0;
        complete     = 1'b0;
        emit         = 1'b0;
        cmp_d1       = 8'h00;
        cmp_d2       = 8'h00;

        if (rx_err) begin
            // Framing error: drop any coincident byte and forget running status
            state_d  = StNoStat;
            status_d = 8'h00;
        end else if (byte_valid) begin
            if (byte_in[7]) begin
                if (byte_in < 8'hF0) begin
                    status_d = byte_in;
                    state_d  = StD1;
                end else if (byte_in < 8'hF8) begin
                    status_d = 8'h00;
                    state_d  = StNoStat;
                end
                // 0xF8..0xFF realtime: no effect on parsing
            end else begin
                case (state_q)
                    StD1: begin
                        d1_d = byte_in;
                        if (is_one_data_byte(status_q[7:4])) begin
                            complete = 1'b1;
                            cmp_d1   = byte_in;
                        end else begin
                            state_d = StD2;
                        end
                    end
                    StD2: begin
                        complete = 1'b1;
                        cmp_d1   = d1_q;
                        cmp_d2   = byte_in;
                        state_d  = StD1;
                    end
                    default: ;
                endcase
            end
        end

        if (complete && ch_pass) begin
            emit = 1'b1;
            case (status_q[7:4])
                NOTE_OFF: note_off_d = 1'b1;
                NOTE_ON: begin
                    // Velocity zero is a note-off by MIDI convention
                    if (cmp_d2 != 8'h00) note_on_d  = 1'b1;
                    else                 note_off_d = 1'b1;
                end
                CTRL_CHG: ctrl_d  = 1'b1;
                PROG_CHG: prog_d  = 1'b1;
                PITCH:    pitch_d = 1'b1;
                // Aftertouch is consumed silently
                default:  emit = 1'b0;
            endcase
            if (emit) begin
                ictrl_d      = cmp_d1;
                ictrl_data_d = cmp_d2;
                cmd_ch_d     = status_q[3:0];
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q      <= StNoStat;
            status_q     <= 8'h00;
            d1_q         <= 8'h00;
            ictrl_q      <= 8'h00;
            ictrl_data_q <= 8'h00;
            cmd_ch_q     <= 4'h0;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            ctrl_q       <= 1'b0;
            prog_q       <= 1'b0;
            pitch_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            d1_q         <= d1_d;
            ictrl_q      <= ictrl_d;
            ictrl_data_q <= ictrl_data_d;
            cmd_ch_q     <= cmd_ch_d;
            note_on_q    <= note_on_d;
            note_off_q   <= note_off_d;
            ctrl_q       <= ctrl_d;
            prog_q       <= prog_d;
            pitch_q      <= pitch_d;
        end
    end

    assign ictrl      = ictrl_q;
    assign ictrl_data = ictrl_data_q;
    assign cmd_ch     = cmd_ch_q;
    assign note_on    = note_on_q;
    assign note_off   = note_off_q;
    assign ctrl_cmd   = ctrl_q;
    assign prog_cmd   = prog_q;
    assign pitch_cmd  = pitch_q;

`ifdef MIDI_ACTIVE_SENSE_EN
    logic sense_arm;
    assign sense_arm = byte_valid && !rx_err && (byte_in == 8'hFE);

    midi_sense_timer #(
        .TIMEOUT(SENSE_TIMEOUT)
    ) u_sense_timer (
        .CLOCK_25   (CLOCK_25),
        .reset_reg_N(reset_reg_N),
        .arm        (sense_arm),
        .reload     (byte_valid),
        .disarm     (rx_err),
        .expire     (all_off)
    );
`else
    logic unused_sense_cfg;
    assign unused_sense_cfg = ^SENSE_TIMEOUT;
    assign all_off = 1'b0;
`endif

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: two instances (omni, and channel-2
// filtered) share one byte stream; expected messages are queued when the
// completing byte is driven and popped when a command pulse appears.
module tb_midi_msg_parser;

    localparam logic [4:0] C_ON    = 5'b10000;
    localparam logic [4:0] C_OFF   = 5'b01000;
    localparam logic [4:0] C_CTRL  = 5'b00100;
    localparam logic [4:0] C_PROG  = 5'b00010;
    localparam logic [4:0] C_PITCH = 5'b00001;

    typedef struct {
        logic [4:0] cmd;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [3:0] ch;
        int         cyc;
    } exp_t;

    logic       CLOCK_25 = 1'b0;
    logic       reset_reg_N;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       rx_err;

    logic [7:0] ictrl0, ictrl_data0, ictrl1, ictrl_data1;
    logic [3:0] cmd_ch0, cmd_ch1;
    logic       on0, off0, ctl0, prg0, pit0, ao0;
    logic       on1, off1, ctl1, prg1, pit1, ao1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    bit         held[2];
    logic [15:0] held_val[2];
    int ao_cnt0 = 0, ao_cnt1 = 0, ao_cyc0 = -1, ao_cyc1 = -1;

    midi_msg_parser #(
        .MIDI_CH(0), .OMNI(1'b1), .SENSE_TIMEOUT(100)
    ) u_dut0 (
        .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .byte_in(byte_in),
        .byte_valid(byte_valid), .rx_err(rx_err), .ictrl(ictrl0),
        .ictrl_data(ictrl_data0), .cmd_ch(cmd_ch0), .note_on(on0), .note_off(off0),
        .ctrl_cmd(ctl0), .prog_cmd(prg0), .pitch_cmd(pit0), .all_off(ao0)
    );

    midi_msg_parser #(
        .MIDI_CH(2), .OMNI(1'b0), .SENSE_TIMEOUT(100)
    ) u_dut1 (
        .CLOCK_25(CLOCK_25), .reset_reg_N(reset_reg_N), .byte_in(byte_in),
        .byte_valid(byte_valid), .rx_err(rx_err), .ictrl(ictrl1),
        .ictrl_data(ictrl_data1), .cmd_ch(cmd_ch1), .note_on(on1), .note_off(off1),
        .ctrl_cmd(ctl1), .prog_cmd(prg1), .pitch_cmd(pit1), .all_off(ao1)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    always @(posedge CLOCK_25) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge CLOCK_25);
        byte_in    = b;
        byte_valid = 1'b1;
        last_cyc   = cyc;
    endtask

    task automatic send_err(input logic [7:0] b);
        @(negedge CLOCK_25);
        byte_in    = b;
        byte_valid = 1'b1;
        rx_err     = 1'b1;
        @(negedge CLOCK_25);
        byte_valid = 1'b0;
        rx_err     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK_25);
            byte_valid = 1'b0;
        end
    endtask

    // Queue an expected message completed by the byte just driven; mask bit i selects DUT i
    task automatic expect_msg(input logic [1:0] mask, input logic [4:0] cmd,
                              input logic [7:0] d1, input logic [7:0] d2, input logic [3:0] ch);
        exp_t e;
        e.cmd = cmd; e.d1 = d1; e.d2 = d2; e.ch = ch; e.cyc = last_cyc;
        if (mask[0]) q0.push_back(e);
        if (mask[1]) q1.push_back(e);
    endtask

    task automatic mon(input int idx, input logic [4:0] p, input logic [7:0] ic,
                       input logic [7:0] id, input logic [3:0] ch);
        exp_t e;
        bit   have;
        have = (idx == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (p != 5'b0) begin
            if (!have) begin
                check_eq($sformatf("unexpected_pulse%0d", idx), 32'(p), 32'h0);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check_eq($sformatf("cmd%0d", idx), 32'(p), 32'(e.cmd));
                check_eq($sformatf("ictrl%0d", idx), 32'(ic), 32'(e.d1));
                check_eq($sformatf("ictrl_data%0d", idx), 32'(id), 32'(e.d2));
                check_eq($sformatf("cmd_ch%0d", idx), 32'(ch), 32'(e.ch));
                check_eq($sformatf("latency%0d", idx), 32'(cyc), 32'(e.cyc + 1));
            end
            held[idx]     = 1'b1;
            held_val[idx] = {ic, id};
        end else if (held[idx]) begin
            // Data must remain stable in the cycle after the pulse
            check_eq($sformatf("hold%0d", idx), 32'({ic, id}), 32'(held_val[idx]));
            held[idx] = 1'b0;
        end
    endtask

    always @(negedge CLOCK_25) begin
        mon(0, {on0, off0, ctl0, prg0, pit0}, ictrl0, ictrl_data0, cmd_ch0);
        mon(1, {on1, off1, ctl1, prg1, pit1}, ictrl1, ictrl_data1, cmd_ch1);
        if (ao0) begin ao_cnt0++; ao_cyc0 = cyc; end
        if (ao1) begin ao_cnt1++; ao_cyc1 = cyc; end
    end

    initial begin
        int t0;
        reset_reg_N = 1'b0;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        rx_err      = 1'b0;
        held[0] = 1'b0; held[1] = 1'b0;
        held_val[0] = '0; held_val[1] = '0;
        idle(2);
        check_eq("rst_ictrl0", 32'(ictrl0), 32'h0);
        check_eq("rst_data0", 32'(ictrl_data0), 32'h0);
        check_eq("rst_ch0", 32'(cmd_ch0), 32'h0);
        check_eq("rst_pulses0", 32'({on0, off0, ctl0, prg0, pit0, ao0}), 32'h0);
        @(negedge CLOCK_25);
        reset_reg_N = 1'b1;
        idle(2);

        // Note on, channel 0 (filtered out by DUT1)
        send(8'h90); send(8'h3C); send(8'h64); expect_msg(2'b01, C_ON, 8'h3C, 8'h64, 4'h0);
        idle(3);
        // Pitch bend plus running status, back-to-back bytes
        send(8'hE0); send(8'h00); send(8'h40); expect_msg(2'b01, C_PITCH, 8'h00, 8'h40, 4'h0);
        send(8'h7F); send(8'h7F); expect_msg(2'b01, C_PITCH, 8'h7F, 8'h7F, 4'h0);
        idle(3);
        // Realtime byte inside a message; velocity 0 -> note off
        send(8'h91); send(8'h40); send(8'hF8); send(8'h00);
        expect_msg(2'b01, C_OFF, 8'h40, 8'h00, 4'h1);
        idle(3);
        // Controller on channel 2 passes both filters; channel 3 only the omni one
        send(8'hB2); send(8'h07); send(8'h50); expect_msg(2'b11, C_CTRL, 8'h07, 8'h50, 4'h2);
        idle(2);
        send(8'hB3); send(8'h08); send(8'h51); expect_msg(2'b01, C_CTRL, 8'h08, 8'h51, 4'h3);
        idle(3);
        check_eq("filt_ictrl1", 32'(ictrl1), 32'h07);
        check_eq("filt_data1", 32'(ictrl_data1), 32'h50);
        check_eq("filt_ch1", 32'(cmd_ch1), 32'h2);
        // Program change with running status, single data byte each
        send(8'hC0); send(8'h05); expect_msg(2'b01, C_PROG, 8'h05, 8'h00, 4'h0);
        send(8'h06); expect_msg(2'b01, C_PROG, 8'h06, 8'h00, 4'h0);
        idle(3);
        // Aftertouch consumed silently
        send(8'hA2); send(8'h10); send(8'h20); send(8'hD2); send(8'h33); send(8'h62);
        idle(3);
        // Framing error drops the coincident byte and running status
        send(8'h92); send(8'h3C); send_err(8'h40); send(8'h40); send(8'h41);
        idle(2);
        send(8'h92); send(8'h3C); send(8'h40); expect_msg(2'b11, C_ON, 8'h3C, 8'h40, 4'h2);
        idle(3);
        // SysEx clears status; its data is ignored
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h3C); send(8'h40);
        idle(3);
        // Asynchronous reset mid-message
        send(8'h90); send(8'h3C);
        idle(2);
        #5 reset_reg_N = 1'b0;
        #1;
        check_eq("mid_rst_ictrl0", 32'(ictrl0), 32'h0);
        check_eq("mid_rst_data0", 32'(ictrl_data0), 32'h0);
        check_eq("mid_rst_ch1", 32'(cmd_ch1), 32'h0);
        @(negedge CLOCK_25);
        reset_reg_N = 1'b1;
        send(8'h40);
        idle(5);

`ifdef MIDI_ACTIVE_SENSE_EN
        ao_cnt0 = 0; ao_cnt1 = 0;
        send(8'hFE); t0 = last_cyc;
        idle(130);
        check_eq("sense_cnt0", 32'(ao_cnt0), 32'd1);
        check_eq("sense_at0", 32'(ao_cyc0), 32'(t0 + 100));
        check_eq("sense_cnt1", 32'(ao_cnt1), 32'd1);
        ao_cnt0 = 0; ao_cnt1 = 0;
        send(8'hFE); t0 = last_cyc;
        idle(89);
        send(8'hF8); t0 = last_cyc;
        idle(130);
        check_eq("sense_rl_cnt0", 32'(ao_cnt0), 32'd1);
        check_eq("sense_rl_at0", 32'(ao_cyc0), 32'(t0 + 100));
        check_eq("sense_rl_at1", 32'(ao_cyc1), 32'(t0 + 100));
`else
        ao_cnt0 = 0; ao_cnt1 = 0;
        send(8'hFE); t0 = last_cyc;
        idle(130);
        check_eq("no_sense0", 32'(ao_cnt0), 32'd0);
        check_eq("no_sense1", 32'(ao_cnt1), 32'd0);
`endif

        idle(3);
        check_eq("sb_empty0", 32'(q0.size()), 32'd0);
        check_eq("sb_empty1", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
